// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
  localparam int          INST_BYTES    = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a target address onto a word boundary.
  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & PC_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// fetch_fifo: small circular queue of fetched {pc, inst} entries.
// Push and pop in the same cycle are legal even when full; clear wins over both.
import ifetch_pkg::*;

module fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_occ
);
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_occ;
  fetch_entry_t  r_mem [DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_wptr <= nxt(r_wptr);
      if (i_pop)  r_rptr <= nxt(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

  assign o_head = r_mem[r_rptr];
  assign o_occ  = r_occ;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, IM request issue with credit check, response
// bypass/queueing and execute-stage redirect.
// Optional IFETCH_STATS_EN adds transfer and bubble counters.
import ifetch_pkg::*;

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_IM_addr,
  input  logic [31:0] i_IM_inst,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   r_pc, r_req_pc;
  logic          r_inflight;
  logic [CW-1:0] w_occ;
  logic          w_q_empty, w_valid, w_deq, w_push, w_pop, w_issue;
  fetch_entry_t  w_head, w_resp;

  assign w_q_empty = (w_occ == '0);
  assign w_resp    = '{pc: r_req_pc, inst: i_IM_inst};
  // Redirect kills the output so a wrong-path instruction is never handed over.
  assign w_valid   = !i_redirect && (!w_q_empty || r_inflight);
  assign w_deq     = w_valid && i_ready;
  // A response is stored unless it was bypassed and taken in the same cycle.
  assign w_push    = !i_redirect && r_inflight && (!w_q_empty || !i_ready);
  assign w_pop     = w_deq && !w_q_empty;
  // Credit check: queued + in flight - leaving must leave room for one more.
  assign w_issue   = (32'(w_occ) + 32'(r_inflight)) < (32'(FQ_DEPTH) + 32'(w_deq));

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect),
    .i_data  (w_resp),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  // Fetch PC, request tracking and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (i_redirect) begin
      r_pc       <= pc_align(i_redirect_pc);
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= r_pc + 32'(INST_BYTES);
      r_req_pc   <= r_pc;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Output select: queue head first, then the bypassed response, else zero.
  always_comb begin
    o_pc   = '0;
    o_inst = '0;
    if (!w_q_empty) begin
      o_pc   = w_head.pc;
      o_inst = w_head.inst;
    end else if (r_inflight) begin
      o_pc   = w_resp.pc;
      o_inst = w_resp.inst;
    end
  end

  assign o_IM_addr = r_pc;
  assign o_valid   = w_valid;

`ifdef IFETCH_STATS_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;

  // Accepted transfers and idle cycles where decode was ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_deq)                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (i_ready && !w_valid)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: per-cycle vector table from reset, hand-written
// redirect/reset sequences, and an in-order PC scoreboard on every transfer.
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] o_IM_addr, im_data, o_inst, o_pc, i_redirect_pc;
  logic        o_valid, i_ready, i_redirect;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_IM_addr     (o_IM_addr),
    .i_IM_inst     (im_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
`ifdef IFETCH_STATS_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_bubble_cnt  (bubble_cnt)
`endif
  );

  // IM model: word k holds 0x1000_0000+k, one cycle read latency, aliases on [15:2].
  always @(posedge clk) im_data <= 32'h1000_0000 + {18'd0, o_IM_addr[15:2]};

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h1000_0000 + {18'd0, pc[15:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected program order from a start address (reset or redirect target).
  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  task automatic sb_check();
    logic [31:0] e;
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc %h expected no transfer", o_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", o_pc, e);
        chk("sb_inst", o_inst, inst_of(e));
      end
    end
  endtask

  // Apply inputs for this cycle, then sample at the falling edge.
  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
    i_ready       = rdy;
    i_redirect    = rd;
    i_redirect_pc = rpc;
    if (rd) expect_stream(rpc & 32'hFFFF_FFFC);
    @(negedge clk);
    sb_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //              rdy   rd    rpc           ev    epc           eaddr
    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h04};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'h08};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h0C};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   32'h14};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  32'h18};
    tbl[10] = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   32'h1C};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104};
    tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h108};

    rst = 1'b1; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_addr", o_IM_addr, RESET_PC);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    rst = 1'b0;
    expect_stream(RESET_PC);

    // Startup, 4-cycle stall, then redirect to 0x103.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_addr", i), o_IM_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), o_pc, tbl[i].epc);
        chk($sformatf("v%0d_inst", i), o_inst, inst_of(tbl[i].epc));
      end
      adv();
    end
`ifdef IFETCH_STATS_EN
    chk("stat_fetch_a", fetch_cnt, 32'd7);
    chk("stat_bubble_a", bubble_cnt, 32'd3);
`endif

    // Fill the queue under stall, then redirect to 0x200 while still stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk("stall_valid", 32'(o_valid), 32'd1);
      adv();
    end
    drive(1'b0, 1'b1, 32'h200); chk("r200_t0_valid", 32'(o_valid), 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0);   chk("r200_t1_valid", 32'(o_valid), 32'd0);
    chk("r200_t1_addr", o_IM_addr, 32'h200); adv();
    drive(1'b1, 1'b0, 32'h0);   chk("r200_t2_valid", 32'(o_valid), 32'd1);
    chk("r200_t2_pc", o_pc, 32'h200); adv();
    drive(1'b1, 1'b0, 32'h0);   chk("r200_t3_pc", o_pc, 32'h204); adv();

    // Redirect to the last word: PC wraps to zero, IM aliases.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC); chk("wrap_t0_valid", 32'(o_valid), 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0); chk("wrap_t1_addr", o_IM_addr, 32'hFFFF_FFFC); adv();
    drive(1'b1, 1'b0, 32'h0); chk("wrap_t2_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_t2_inst", o_inst, 32'h1000_3FFF);
    chk("wrap_t2_addr", o_IM_addr, 32'h0); adv();
    drive(1'b1, 1'b0, 32'h0); chk("wrap_t3_pc", o_pc, 32'h0);
    chk("wrap_t3_inst", o_inst, 32'h1000_0000); adv();

    // Back-to-back redirects: the second one wins.
    drive(1'b1, 1'b1, 32'h300); chk("b2b_t0_valid", 32'(o_valid), 32'd0); adv();
    drive(1'b1, 1'b1, 32'h400); chk("b2b_t1_valid", 32'(o_valid), 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0);   chk("b2b_t2_valid", 32'(o_valid), 32'd0);
    chk("b2b_t2_addr", o_IM_addr, 32'h400); adv();
    drive(1'b1, 1'b0, 32'h0);   chk("b2b_t3_pc", o_pc, 32'h400); adv();

    // Asynchronous reset mid-cycle with a request in flight.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_addr", o_IM_addr, RESET_PC);
`ifdef IFETCH_STATS_EN
    chk("arst_fetch", fetch_cnt, 32'd0);
    chk("arst_bubble", bubble_cnt, 32'd0);
`endif
    adv();
    rst = 1'b0;
    expect_stream(RESET_PC);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (i == 0) chk("post_rst_valid0", 32'(o_valid), 32'd0);
      if (i == 1) chk("post_rst_pc1", o_pc, RESET_PC);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      adv();
    end
`ifdef IFETCH_STATS_EN
    chk("stat_fetch_b", fetch_cnt, 32'd9);
    chk("stat_bubble_b", bubble_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
